// File: rtl/fft_stage_ctrl_if.sv
// ----------------------------------------------------------------------------
// fft_stage_ctrl_if
//   Bundles the control and RAM-addressing signals of the radix-2 FFT stage
//   sequencer.
//   master : the sequencer (drives busy/done/stage, read and write-back bus)
//   slave  : the FFT core / RAM side (drives start and stall)
//   Signals:
//     start      core -> seq   start request, sampled in IDLE
//     stall      core -> seq   hold read issue
//     busy       seq  -> core  run in progress (issue or drain)
//     done       seq  -> core  one-cycle completion pulse
//     stage      seq  -> core  current stage index
//     rd_valid   seq  -> core  read pair / twiddle address valid
//     rd_addr_a  seq  -> core  upper-leg read address
//     rd_addr_b  seq  -> core  lower-leg read address
//     tw_addr    seq  -> core  twiddle ROM address (zero-extended)
//     wr_valid   seq  -> core  write-back strobe
//     wr_addr_a  seq  -> core  upper-leg write address
//     wr_addr_b  seq  -> core  lower-leg write address
// ----------------------------------------------------------------------------
interface fft_stage_ctrl_if #(
   parameter int LOG2N = 10
);
   logic             start;
   logic             stall;
   logic             busy;
   logic             done;
   logic [3:0]       stage;
   logic             rd_valid;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [15:0]      tw_addr;
   logic             wr_valid;
   logic [LOG2N-1:0] wr_addr_a;
   logic [LOG2N-1:0] wr_addr_b;

   modport master (
      input  start, stall,
      output busy, done, stage,
      output rd_valid, rd_addr_a, rd_addr_b, tw_addr,
      output wr_valid, wr_addr_a, wr_addr_b
   );

   modport slave (
      output start, stall,
      input  busy, done, stage,
      input  rd_valid, rd_addr_a, rd_addr_b, tw_addr,
      input  wr_valid, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/fft_stage_ctrl.sv
// ----------------------------------------------------------------------------
// fft_stage_ctrl
//   Sequencer for an in-place radix-2 DIT FFT core. For each of LOG2N stages
//   it issues N/2 butterflies (sample read pair A/B plus twiddle address),
//   delays the pair addresses by the butterfly latency to drive write-back,
//   and drains the pipeline between stages so no read overtakes a pending
//   in-place write.
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  synchronous active-high reset
//     bus  fft_stage_ctrl_if.master (start/stall in; busy, done, stage,
//          read pair, twiddle address and write-back bus out)
// ----------------------------------------------------------------------------
module fft_stage_ctrl #(
   parameter int N      = 1024,
   parameter int LOG2N  = 10,
   parameter int BF_LAT = 4
) (
   input logic                clk,
   input logic                rst,
   fft_stage_ctrl_if.master   bus
);

   localparam int HALF = N / 2;
   localparam int KW   = LOG2N - 1;
   localparam int DW   = $clog2(BF_LAT + 1);

   localparam logic [KW-1:0] K_LAST     = KW'(HALF - 1);
   localparam logic [DW-1:0] D_LAST     = DW'(BF_LAT - 1);
   localparam logic [3:0]    STAGE_LAST = 4'(LOG2N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic [3:0]       stage_q;
   logic [DW-1:0]    drain_q;

   // registered outputs
   logic             busy_q;
   logic             done_q;
   logic [3:0]       stage_o_q;
   logic             rd_valid_q;
   logic [LOG2N-1:0] rd_a_q;
   logic [LOG2N-1:0] rd_b_q;
   logic [15:0]      tw_q;

   // write-back delay line
   logic [BF_LAT-1:0] wv_q;
   logic [LOG2N-1:0]  wa_q [BF_LAT];
   logic [LOG2N-1:0]  wb_q [BF_LAT];

   // next read addresses for the current (stage, k)
   logic [LOG2N-1:0] span_d;
   logic [LOG2N-1:0] kx_d;
   logic [LOG2N-1:0] pos_d;
   logic [LOG2N-1:0] addr_a_d;
   logic [LOG2N-1:0] addr_b_d;
   logic [15:0]      tw_d;

   // a = (grp << (s+1)) | pos splits k at bit s and inserts a zero there;
   // b is the same address with that inserted bit set.
   always_comb begin
      span_d   = '0;
      kx_d     = '0;
      pos_d    = '0;
      addr_a_d = '0;
      addr_b_d = '0;
      tw_d     = '0;
      span_d   = LOG2N'(1) << stage_q;
      kx_d     = LOG2N'(k_q);
      pos_d    = kx_d & (span_d - LOG2N'(1));
      addr_a_d = ((kx_d >> stage_q) << (stage_q + 4'd1)) | pos_d;
      addr_b_d = addr_a_d + span_d;
      tw_d     = 16'(pos_d) << (STAGE_LAST - stage_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         stage_q    <= '0;
         drain_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         stage_o_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_a_q     <= '0;
         rd_b_q     <= '0;
         tw_q       <= '0;
      end else begin
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               busy_q    <= 1'b0;
               stage_o_q <= '0;
               // The cycle carrying the done pulse is already IDLE internally;
               // a start seen there still belongs to the finished run.
               if (bus.start && !done_q) begin
                  state_q <= S_ISSUE;
                  k_q     <= '0;
                  stage_q <= '0;
                  drain_q <= '0;
               end
            end
            S_ISSUE: begin
               busy_q    <= 1'b1;
               stage_o_q <= stage_q;
               if (!bus.stall) begin
                  rd_valid_q <= 1'b1;
                  rd_a_q     <= addr_a_d;
                  rd_b_q     <= addr_b_d;
                  tw_q       <= tw_d;
                  if (k_q == K_LAST) begin
                     state_q <= S_DRAIN;
                     drain_q <= '0;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               busy_q    <= 1'b1;
               stage_o_q <= stage_q;
               if (drain_q == D_LAST) begin
                  drain_q <= '0;
                  if (stage_q == STAGE_LAST) begin
                     state_q <= S_DONE;
                  end else begin
                     stage_q <= stage_q + 4'd1;
                     k_q     <= '0;
                     state_q <= S_ISSUE;
                  end
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            S_DONE: begin
               busy_q    <= 1'b0;
               done_q    <= 1'b1;
               stage_o_q <= '0;
               state_q   <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Free-running: shifts every cycle regardless of state or stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         wv_q <= '0;
         for (int unsigned i = 0; i < BF_LAT; i++) begin
            wa_q[i] <= '0;
            wb_q[i] <= '0;
         end
      end else begin
         wv_q[0] <= rd_valid_q;
         wa_q[0] <= rd_a_q;
         wb_q[0] <= rd_b_q;
         for (int unsigned i = 1; i < BF_LAT; i++) begin
            wv_q[i] <= wv_q[i-1];
            wa_q[i] <= wa_q[i-1];
            wb_q[i] <= wb_q[i-1];
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.stage     = stage_o_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_addr_a = rd_a_q;
   assign bus.rd_addr_b = rd_b_q;
   assign bus.tw_addr   = tw_q;
   assign bus.wr_valid  = wv_q[BF_LAT-1];
   assign bus.wr_addr_a = wa_q[BF_LAT-1];
   assign bus.wr_addr_b = wb_q[BF_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_stage_ctrl
//   Directed bench for fft_stage_ctrl with N=8, LOG2N=3, BF_LAT=4.
//   Cycle c counts rising edges after the edge that samples start (edge 0);
//   outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_stage_ctrl;

   localparam int N      = 8;
   localparam int LOG2N  = 3;
   localparam int BF_LAT = 4;

   logic clk;
   logic rst;

   int tests_run    = 0;
   int tests_failed = 0;

   fft_stage_ctrl_if #(.LOG2N(LOG2N)) bus ();

   fft_stage_ctrl #(
      .N      (N),
      .LOG2N  (LOG2N),
      .BF_LAT (BF_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed {a, b, tw} for read index = stage*4 + k (N=8).
   function automatic logic [8:0] row(input int idx);
      case (idx)
         0:  row = {3'd0, 3'd1, 3'd0};
         1:  row = {3'd2, 3'd3, 3'd0};
         2:  row = {3'd4, 3'd5, 3'd0};
         3:  row = {3'd6, 3'd7, 3'd0};
         4:  row = {3'd0, 3'd2, 3'd0};
         5:  row = {3'd1, 3'd3, 3'd2};
         6:  row = {3'd4, 3'd6, 3'd0};
         7:  row = {3'd5, 3'd7, 3'd2};
         8:  row = {3'd0, 3'd4, 3'd0};
         9:  row = {3'd1, 3'd5, 3'd1};
         10: row = {3'd2, 3'd6, 3'd2};
         11: row = {3'd3, 3'd7, 3'd3};
         default: row = '0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.start = 1'b0;
      bus.stall = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Drives start so that it is sampled at the next edge (edge 0).
   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      tick();
      tick();
      tests_run++;
      if ({bus.busy, bus.done, bus.stage, bus.rd_valid, bus.wr_valid} !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got=%b exp=0",
                  {bus.busy, bus.done, bus.stage, bus.rd_valid, bus.wr_valid});
      end
      tests_run++;
      if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b} !== '0) begin
         tests_failed++;
         $display("FAIL reset_addr got=%h exp=0",
                  {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_run();
      logic       exp_rv;
      logic [8:0] r;
      int         idx;
      do_reset();
      pulse_start();
      for (int c = 1; c <= 30; c++) begin
         tick();
         exp_rv = (c <= 24) && (((c - 1) % 8) < 4);
         idx    = ((c - 1) / 8) * 4 + ((c - 1) % 8);
         tests_run++;
         if (bus.rd_valid !== exp_rv) begin
            tests_failed++;
            $display("FAIL basic_rd_valid cyc=%0d got=%b exp=%b", c, bus.rd_valid, exp_rv);
         end
         tests_run++;
         if (bus.busy !== (c <= 24)) begin
            tests_failed++;
            $display("FAIL basic_busy cyc=%0d got=%b exp=%b", c, bus.busy, (c <= 24));
         end
         tests_run++;
         if (bus.done !== (c == 25)) begin
            tests_failed++;
            $display("FAIL basic_done cyc=%0d got=%b exp=%b", c, bus.done, (c == 25));
         end
         if (c <= 24) begin
            tests_run++;
            if (bus.stage !== 4'((c - 1) / 8)) begin
               tests_failed++;
               $display("FAIL basic_stage cyc=%0d got=%0d exp=%0d", c, bus.stage, (c - 1) / 8);
            end
         end
         if (exp_rv) begin
            r = row(idx);
            tests_run++;
            if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== {r[8:6], r[5:3], 13'd0, r[2:0]}) begin
               tests_failed++;
               $display("FAIL basic_addr cyc=%0d got=a%0d b%0d tw%0d exp=a%0d b%0d tw%0d", c,
                        bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, r[8:6], r[5:3], r[2:0]);
            end
         end
      end
   endtask

   task automatic test_writeback();
      logic       exp_wv;
      logic [8:0] r;
      int         idx;
      int         wr_cnt [3];
      int         last_wr [3];
      int         first_rd [3];
      for (int s = 0; s < 3; s++) begin
         wr_cnt[s]   = 0;
         last_wr[s]  = -1;
         first_rd[s] = 999;
      end
      do_reset();
      pulse_start();
      for (int c = 1; c <= 32; c++) begin
         tick();
         exp_wv = (c >= 5) && (c <= 28) && (((c - 5) % 8) < 4);
         idx    = ((c - 5) / 8) * 4 + ((c - 5) % 8);
         tests_run++;
         if (bus.wr_valid !== exp_wv) begin
            tests_failed++;
            $display("FAIL wb_valid cyc=%0d got=%b exp=%b", c, bus.wr_valid, exp_wv);
         end
         if (exp_wv) begin
            r = row(idx);
            tests_run++;
            if ({bus.wr_addr_a, bus.wr_addr_b} !== {r[8:6], r[5:3]}) begin
               tests_failed++;
               $display("FAIL wb_addr cyc=%0d got=a%0d b%0d exp=a%0d b%0d", c,
                        bus.wr_addr_a, bus.wr_addr_b, r[8:6], r[5:3]);
            end
         end
         if (bus.wr_valid === 1'b1 && c >= 5 && c <= 28) begin
            wr_cnt[(c - 5) / 8]++;
            last_wr[(c - 5) / 8] = c;
         end
         if (bus.rd_valid === 1'b1 && c <= 24 && first_rd[(c - 1) / 8] == 999)
            first_rd[(c - 1) / 8] = c;
      end
      for (int s = 0; s < 3; s++) begin
         tests_run++;
         if (wr_cnt[s] != N / 2) begin
            tests_failed++;
            $display("FAIL wb_count stage=%0d got=%0d exp=%0d", s, wr_cnt[s], N / 2);
         end
      end
      for (int s = 0; s < 2; s++) begin
         tests_run++;
         if (!(first_rd[s + 1] > last_wr[s])) begin
            tests_failed++;
            $display("FAIL wb_order stage=%0d got=first_rd%0d last_wr%0d exp=first_rd>last_wr",
                     s, first_rd[s + 1], last_wr[s]);
         end
      end
   endtask

   task automatic test_stall();
      logic       exp_rv [40];
      int         exp_idx [40];
      int         cyc;
      logic [8:0] r;
      for (int c = 0; c < 40; c++) begin
         exp_rv[c]  = 1'b0;
         exp_idx[c] = -1;
      end
      for (int s = 0; s < 3; s++) begin
         for (int kk = 0; kk < 4; kk++) begin
            cyc = 1 + 8 * s + kk + ((s > 0 || kk >= 2) ? 3 : 0);
            exp_rv[cyc]  = 1'b1;
            exp_idx[cyc] = s * 4 + kk;
         end
      end
      // addresses hold the k=1 values through the stall
      for (int c = 3; c <= 5; c++) exp_idx[c] = 1;
      do_reset();
      pulse_start();
      for (int c = 1; c <= 32; c++) begin
         tick();
         tests_run++;
         if (bus.rd_valid !== exp_rv[c]) begin
            tests_failed++;
            $display("FAIL stall_rd_valid cyc=%0d got=%b exp=%b", c, bus.rd_valid, exp_rv[c]);
         end
         tests_run++;
         if (bus.done !== (c == 28)) begin
            tests_failed++;
            $display("FAIL stall_done cyc=%0d got=%b exp=%b", c, bus.done, (c == 28));
         end
         tests_run++;
         if (bus.busy !== (c <= 27)) begin
            tests_failed++;
            $display("FAIL stall_busy cyc=%0d got=%b exp=%b", c, bus.busy, (c <= 27));
         end
         if (exp_idx[c] >= 0) begin
            r = row(exp_idx[c]);
            tests_run++;
            if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== {r[8:6], r[5:3], 13'd0, r[2:0]}) begin
               tests_failed++;
               $display("FAIL stall_addr cyc=%0d got=a%0d b%0d tw%0d exp=a%0d b%0d tw%0d", c,
                        bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, r[8:6], r[5:3], r[2:0]);
            end
         end
         if (c >= 3 && c <= 5) begin
            tests_run++;
            if (bus.stage !== 4'd0) begin
               tests_failed++;
               $display("FAIL stall_stage cyc=%0d got=%0d exp=0", c, bus.stage);
            end
         end
         // stall during ISSUE (edges 3..5), then during DRAIN (edges 9..10, ignored)
         if (c == 2) bus.stall = 1'b1;
         if (c == 5) bus.stall = 1'b0;
         if (c == 8) bus.stall = 1'b1;
         if (c == 10) bus.stall = 1'b0;
      end
   endtask

   task automatic test_start_ignored();
      logic exp_rv;
      do_reset();
      pulse_start();
      for (int c = 1; c <= 28; c++) begin
         tick();
         exp_rv = ((c <= 24) && (((c - 1) % 8) < 4)) || (c == 28);
         tests_run++;
         if (bus.rd_valid !== exp_rv) begin
            tests_failed++;
            $display("FAIL start_rd_valid cyc=%0d got=%b exp=%b", c, bus.rd_valid, exp_rv);
         end
         tests_run++;
         if (bus.done !== (c == 25)) begin
            tests_failed++;
            $display("FAIL start_done cyc=%0d got=%b exp=%b", c, bus.done, (c == 25));
         end
         tests_run++;
         if (bus.busy !== (c <= 24 || c == 28)) begin
            tests_failed++;
            $display("FAIL start_busy cyc=%0d got=%b exp=%b", c, bus.busy, (c <= 24 || c == 28));
         end
         if (c <= 24) begin
            tests_run++;
            if (bus.stage !== 4'((c - 1) / 8)) begin
               tests_failed++;
               $display("FAIL start_stage cyc=%0d got=%0d exp=%0d", c, bus.stage, (c - 1) / 8);
            end
         end
         if (c == 28) begin
            tests_run++;
            if ({bus.stage, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== {4'd0, 3'd0, 3'd1, 16'd0}) begin
               tests_failed++;
               $display("FAIL start_rerun cyc=%0d got=s%0d a%0d b%0d tw%0d exp=s0 a0 b1 tw0", c,
                        bus.stage, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
            end
         end
         // start during ISSUE, during the done cycle, then the cycle after done
         if (c == 3)  bus.start = 1'b1;
         if (c == 4)  bus.start = 1'b0;
         if (c == 25) bus.start = 1'b1;
         if (c == 27) bus.start = 1'b0;
      end
   endtask

   task automatic test_reset_midrun();
      do_reset();
      pulse_start();
      for (int c = 1; c <= 45; c++) begin
         tick();
         if (c == 10) begin
            tests_run++;
            if ({bus.rd_valid, bus.stage} !== {1'b1, 4'd1}) begin
               tests_failed++;
               $display("FAIL midrst_pre cyc=%0d got=rv%b s%0d exp=rv1 s1", c, bus.rd_valid, bus.stage);
            end
            rst = 1'b1;
         end
         if (c == 11) begin
            tests_run++;
            if ({bus.busy, bus.done, bus.stage, bus.rd_valid, bus.wr_valid} !== 8'd0) begin
               tests_failed++;
               $display("FAIL midrst_ctrl cyc=%0d got=%b exp=0", c,
                        {bus.busy, bus.done, bus.stage, bus.rd_valid, bus.wr_valid});
            end
            tests_run++;
            if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b} !== '0) begin
               tests_failed++;
               $display("FAIL midrst_addr cyc=%0d got=%h exp=0", c,
                        {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b});
            end
            rst = 1'b0;
         end
         if (c > 11) begin
            tests_run++;
            if ({bus.done, bus.wr_valid, bus.rd_valid, bus.busy} !== 4'd0) begin
               tests_failed++;
               $display("FAIL midrst_quiet cyc=%0d got=d%b wv%b rv%b bz%b exp=0", c,
                        bus.done, bus.wr_valid, bus.rd_valid, bus.busy);
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      test_reset();
      test_basic_run();
      test_writeback();
      test_stall();
      test_start_ignored();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
